// File: rtl/vga_timing_pipe.sv
// rtl/vga_timing_pipe.sv - raster timing generator with text-cell coordinates and a fixed output delay
//
// Purpose: counts pixel clocks across each line and lines across each frame.
//   From those counts it produces the sync pulses, the visible-pixel qualifier,
//   pixel and text-cell coordinates, and line/frame start strobes. All of these
//   are delayed by PIPE_DELAY register stages so they line up with the
//   downstream character and font fetch latency.
// Ports:
//   clk         pixel clock
//   reset       asynchronous active-low reset
//   vga_hs      horizontal sync, level HS_POL while active
//   vga_vs      vertical sync, level VS_POL while active
//   disp        visible-pixel qualifier
//   x_pos/y_pos visible pixel coordinates (0 outside the visible area)
//   col/row     text cell coordinates
//   cell_x/y    pixel position inside the current cell
//   line_start  first visible pixel of each visible line
//   frame_start visible pixel (0,0) of each frame
module vga_timing_pipe #(
  parameter int H_SYNC     = 112,
  parameter int H_BACK     = 248,
  parameter int H_DISP     = 1280,
  parameter int H_FRONT    = 48,
  parameter int V_SYNC     = 3,
  parameter int V_BACK     = 38,
  parameter int V_DISP     = 1024,
  parameter int V_FRONT    = 1,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int CELL_W     = 8,
  parameter int CELL_H     = 16,
  parameter int PIPE_DELAY = 2,
  localparam int NCOL = (H_DISP + CELL_W - 1) / CELL_W,
  localparam int NROW = (V_DISP + CELL_H - 1) / CELL_H,
  localparam int XW   = (H_DISP > 1) ? $clog2(H_DISP) : 1,
  localparam int YW   = (V_DISP > 1) ? $clog2(V_DISP) : 1,
  localparam int CW   = (NCOL > 1) ? $clog2(NCOL) : 1,
  localparam int RW   = (NROW > 1) ? $clog2(NROW) : 1,
  localparam int CXW  = (CELL_W > 1) ? $clog2(CELL_W) : 1,
  localparam int CYW  = (CELL_H > 1) ? $clog2(CELL_H) : 1
) (
  input  logic           clk,
  input  logic           reset,
  output logic           vga_hs,
  output logic           vga_vs,
  output logic           disp,
  output logic [XW-1:0]  x_pos,
  output logic [YW-1:0]  y_pos,
  output logic [CW-1:0]  col,
  output logic [RW-1:0]  row,
  output logic [CXW-1:0] cell_x,
  output logic [CYW-1:0] cell_y,
  output logic           line_start,
  output logic           frame_start
);

  localparam int H_LIMIT = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_LIMIT = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int H_VS    = H_SYNC + H_BACK;
  localparam int H_VE    = H_VS + H_DISP;
  localparam int V_VS    = V_SYNC + V_BACK;
  localparam int V_VE    = V_VS + V_DISP;
  localparam int HCW     = (H_LIMIT > 1) ? $clog2(H_LIMIT) : 1;
  localparam int VCW     = (V_LIMIT > 1) ? $clog2(V_LIMIT) : 1;
  localparam int BW      = 5 + XW + YW + CW + RW + CXW + CYW;
  // Reset bundle: syncs inactive, everything else zero.
  localparam logic [BW-1:0] RST_VAL = {~HS_POL, ~VS_POL, {(BW-2){1'b0}}};

  logic [HCW-1:0] x_cnt, x_nxt;
  logic [VCW-1:0] y_cnt, y_nxt;
  logic           x_last, y_last;
  logic [31:0]    xw, yw, xnw, ynw;
  logic           x_vis, y_vis, xn_vis, yn_vis;

  logic [CXW-1:0] cx_q;
  logic [CYW-1:0] cy_q;
  logic [CW-1:0]  col_q;
  logic [RW-1:0]  row_q;

  assign x_last = (x_cnt == HCW'(H_LIMIT - 1));
  assign y_last = (y_cnt == VCW'(V_LIMIT - 1));

  always_comb begin
    x_nxt = x_last ? '0 : x_cnt + 1'b1;
    y_nxt = y_cnt;
    if (x_last) y_nxt = y_last ? '0 : y_cnt + 1'b1;
  end

  // Region tests are done on zero-extended counts so the bounds never truncate.
  assign xw     = 32'(x_cnt);
  assign yw     = 32'(y_cnt);
  assign xnw    = 32'(x_nxt);
  assign ynw    = 32'(y_nxt);
  assign x_vis  = (xw >= H_VS) && (xw < H_VE);
  assign y_vis  = (yw >= V_VS) && (yw < V_VE);
  assign xn_vis = (xnw >= H_VS) && (xnw < H_VE);
  assign yn_vis = (ynw >= V_VS) && (ynw < V_VE);

  // Cell counters look one state ahead so they always describe the current
  // x_cnt/y_cnt, replacing a divide/modulo of the pixel position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
      cx_q  <= '0;
      col_q <= '0;
      cy_q  <= '0;
      row_q <= '0;
    end else begin
      x_cnt <= x_nxt;
      y_cnt <= y_nxt;
      if (xnw == H_VS) begin
        cx_q  <= '0;
        col_q <= '0;
      end else if (xn_vis) begin
        if (cx_q == CXW'(CELL_W - 1)) begin
          cx_q  <= '0;
          col_q <= col_q + 1'b1;
        end else begin
          cx_q <= cx_q + 1'b1;
        end
      end
      if (x_last) begin
        if (ynw == V_VS) begin
          cy_q  <= '0;
          row_q <= '0;
        end else if (yn_vis) begin
          if (cy_q == CYW'(CELL_H - 1)) begin
            cy_q  <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            cy_q <= cy_q + 1'b1;
          end
        end
      end
    end
  end

  logic           s0_disp, s0_ls, s0_fs;
  logic [XW-1:0]  s0_x;
  logic [YW-1:0]  s0_y;
  logic [BW-1:0]  s0;

  always_comb begin
    s0_disp = x_vis && y_vis;
    s0_x    = s0_disp ? XW'(xw - H_VS) : '0;
    s0_y    = s0_disp ? YW'(yw - V_VS) : '0;
    s0_ls   = s0_disp && (s0_x == '0);
    s0_fs   = s0_ls && (s0_y == '0);
    s0 = {(xw < H_SYNC) ? HS_POL : ~HS_POL,
          (yw < V_SYNC) ? VS_POL : ~VS_POL,
          s0_disp, s0_ls, s0_fs, s0_x, s0_y,
          s0_disp ? col_q : '0,
          s0_disp ? row_q : '0,
          s0_disp ? cx_q  : '0,
          s0_disp ? cy_q  : '0};
  end

  logic [BW-1:0] pipe [PIPE_DELAY];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) pipe[i] <= RST_VAL;
    end else begin
      pipe[0] <= s0;
      for (int i = 1; i < PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {vga_hs, vga_vs, disp, line_start, frame_start,
          x_pos, y_pos, col, row, cell_x, cell_y} = pipe[PIPE_DELAY-1];

endmodule

// File: tb/tb_vga_timing_pipe.sv
// tb/tb_vga_timing_pipe.sv - scoreboard bench for vga_timing_pipe over small and wide configurations
module tb_vga_timing_pipe;

  typedef struct packed {
    logic        hs, vs, disp, ls, fs;
    logic [15:0] x, y, col, row, cx, cy;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // DUTs 0..3: small config with PIPE_DELAY 2,1,3,5. DUT 4: wide horizontal timing.
  obs_t obs [5];

  logic       s_hs [4], s_vs [4], s_disp [4], s_ls [4], s_fs [4];
  logic [2:0] s_x  [4];
  logic [1:0] s_y  [4];
  logic [1:0] s_col[4];
  logic [0:0] s_row[4];
  logic [1:0] s_cx [4];
  logic [0:0] s_cy [4];

  for (genvar g = 0; g < 4; g++) begin : g_small
    vga_timing_pipe #(
      .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(1),
      .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .CELL_W(3), .CELL_H(2),
      .PIPE_DELAY((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 5)
    ) u_dut (
      .clk(clk), .reset(reset),
      .vga_hs(s_hs[g]), .vga_vs(s_vs[g]), .disp(s_disp[g]),
      .x_pos(s_x[g]), .y_pos(s_y[g]), .col(s_col[g]), .row(s_row[g]),
      .cell_x(s_cx[g]), .cell_y(s_cy[g]),
      .line_start(s_ls[g]), .frame_start(s_fs[g])
    );
    assign obs[g] = {s_hs[g], s_vs[g], s_disp[g], s_ls[g], s_fs[g],
                     16'(s_x[g]), 16'(s_y[g]), 16'(s_col[g]), 16'(s_row[g]),
                     16'(s_cx[g]), 16'(s_cy[g])};
  end

  logic        b_hs, b_vs, b_disp, b_ls, b_fs;
  logic [10:0] b_x;
  logic [1:0]  b_y;
  logic [7:0]  b_col;
  logic [0:0]  b_row;
  logic [2:0]  b_cx;
  logic [3:0]  b_cy;

  vga_timing_pipe #(
    .H_SYNC(112), .H_BACK(248), .H_DISP(1280), .H_FRONT(48),
    .V_SYNC(3), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CELL_W(8), .CELL_H(16), .PIPE_DELAY(1)
  ) u_big (
    .clk(clk), .reset(reset),
    .vga_hs(b_hs), .vga_vs(b_vs), .disp(b_disp),
    .x_pos(b_x), .y_pos(b_y), .col(b_col), .row(b_row),
    .cell_x(b_cx), .cell_y(b_cy),
    .line_start(b_ls), .frame_start(b_fs)
  );
  assign obs[4] = {b_hs, b_vs, b_disp, b_ls, b_fs, 16'(b_x), 16'(b_y),
                   16'(b_col), 16'(b_row), 16'(b_cx), 16'(b_cy)};

  // Reference model: direct arithmetic on the linear state index.
  function automatic obs_t model(input int hsy, hb, hd, hf, vsy, vb, vd, vf,
                                 input int cw, ch, input bit hp, vp, input int n);
    obs_t o;
    int hl, x, y, xp, yp;
    hl = hsy + hb + hd + hf;
    x  = n % hl;
    y  = n / hl;
    o  = '0;
    o.hs = (x < hsy) ? hp : ~hp;
    o.vs = (y < vsy) ? vp : ~vp;
    o.disp = (x >= hsy + hb) && (x < hsy + hb + hd) && (y >= vsy + vb) && (y < vsy + vb + vd);
    if (o.disp) begin
      xp = x - hsy - hb;
      yp = y - vsy - vb;
      o.x = 16'(xp);
      o.y = 16'(yp);
      o.col = 16'(xp / cw);
      o.row = 16'(yp / ch);
      o.cx = 16'(xp % cw);
      o.cy = 16'(yp % ch);
      o.ls = (xp == 0);
      o.fs = (xp == 0) && (yp == 0);
    end
    return o;
  endfunction

  function automatic obs_t exp_of(input int i, input int n);
    if (i == 4) return model(112, 248, 1280, 48, 3, 2, 4, 1, 8, 16, 1'b1, 1'b1, n);
    return model(2, 3, 8, 1, 1, 1, 4, 1, 3, 2, 1'b0, 1'b0, n);
  endfunction

  function automatic obs_t rst_of(input int i);
    obs_t o;
    o = '0;
    o.hs = (i == 4) ? 1'b0 : 1'b1;
    o.vs = (i == 4) ? 1'b0 : 1'b1;
    return o;
  endfunction

  function automatic int pd_of(input int i);
    case (i)
      0: return 2;
      2: return 3;
      3: return 5;
      default: return 1;
    endcase
  endfunction

  function automatic int total_of(input int i);
    return (i == 4) ? 1688 * 10 : 14 * 7;
  endfunction

  obs_t sb [5][$];
  int   n_st [5];
  int   k;
  int   phase;

  // Phase statistics.
  int hs_low, vs_low, disp_cnt, big_hs, big_vs;
  int fs_q[$];
  int ls_q[$];
  logic [15:0] cx_got [8];
  logic [15:0] col_got[8];
  logic [15:0] cy_got [4];
  logic [15:0] row_got[4];
  obs_t big_last;

  task automatic init_sb();
    for (int i = 0; i < 5; i++) begin
      sb[i].delete();
      n_st[i] = 0;
      for (int j = 0; j < pd_of(i) - 1; j++) sb[i].push_back(rst_of(i));
    end
    k = 0;
    fs_q.delete();
    ls_q.delete();
  endtask

  task automatic tick();
    obs_t e;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      sb[i].push_back(exp_of(i, n_st[i]));
      n_st[i] = (n_st[i] + 1) % total_of(i);
    end
    #1;
    k++;
    for (int i = 0; i < 5; i++) begin
      e = sb[i].pop_front();
      check($sformatf("stream%0d_k%0d_p%0d", i, k, phase), obs[i], e);
    end
    if (obs[0].fs) fs_q.push_back(k);
    if (obs[0].ls && k <= 98) ls_q.push_back(k);
    if (phase == 0 && k <= 196) begin
      hs_low   += (obs[0].hs == 1'b0) ? 1 : 0;
      vs_low   += (obs[0].vs == 1'b0) ? 1 : 0;
      disp_cnt += obs[0].disp ? 1 : 0;
      if (k >= 35 && k <= 42) begin
        cx_got[k-35]  = obs[0].cx;
        col_got[k-35] = obs[0].col;
      end
      if (k >= 35 && k <= 77 && (k - 35) % 14 == 0) begin
        cy_got[(k-35)/14]  = obs[0].cy;
        row_got[(k-35)/14] = obs[0].row;
      end
    end
    if (phase == 1) begin
      if (k >= 2 && k <= 1689)  big_hs += obs[4].hs ? 1 : 0;
      if (k >= 2 && k <= 16881) big_vs += obs[4].vs ? 1 : 0;
      if (k == 15144) big_last = obs[4];
    end
  endtask

  initial begin
    logic [15:0] cx_tab  [8];
    logic [15:0] col_tab [8];
    logic [15:0] cy_tab  [4];
    logic [15:0] row_tab [4];
    cx_tab  = '{0, 1, 2, 0, 1, 2, 0, 1};
    col_tab = '{0, 0, 0, 1, 1, 1, 2, 2};
    cy_tab  = '{0, 1, 0, 1};
    row_tab = '{0, 0, 1, 1};
    hs_low = 0; vs_low = 0; disp_cnt = 0; big_hs = 0; big_vs = 0;
    big_last = '0;
    phase = 0;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) check($sformatf("por_reset%0d", i), obs[i], rst_of(i));
    @(negedge clk);
    reset = 1'b1;
    init_sb();

    repeat (300) tick();

    check("hs_low_count", 128'(hs_low), 128'(28));
    check("vs_low_count", 128'(vs_low), 128'(28));
    check("disp_count", 128'(disp_cnt), 128'(64));
    check("fs_count", 128'(fs_q.size()), 128'(3));
    if (fs_q.size() >= 2) begin
      check("fs_first_edge", 128'(fs_q[0]), 128'(35));
      check("fs_second_edge", 128'(fs_q[1]), 128'(133));
    end
    check("ls_count_frame0", 128'(ls_q.size()), 128'(4));
    for (int j = 0; j < ls_q.size() && j < 4; j++)
      check($sformatf("ls_edge%0d", j), 128'(ls_q[j]), 128'(35 + 14 * j));
    for (int j = 0; j < 8; j++) begin
      check($sformatf("cell_x_x%0d", j), 128'(cx_got[j]), 128'(cx_tab[j]));
      check($sformatf("col_x%0d", j), 128'(col_got[j]), 128'(col_tab[j]));
    end
    for (int j = 0; j < 4; j++) begin
      check($sformatf("cell_y_y%0d", j), 128'(cy_got[j]), 128'(cy_tab[j]));
      check($sformatf("row_y%0d", j), 128'(row_got[j]), 128'(row_tab[j]));
    end

    // Mid-frame reset held across one clock edge.
    reset = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) check($sformatf("mid_reset_now%0d", i), obs[i], rst_of(i));
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) check($sformatf("mid_reset_held%0d", i), obs[i], rst_of(i));
    @(negedge clk);
    reset = 1'b1;
    init_sb();
    phase = 1;

    repeat (16900) tick();

    if (fs_q.size() >= 1) check("restart_fs_edge", 128'(fs_q[0]), 128'(35));
    else check("restart_fs_seen", 128'(0), 128'(1));
    check("big_hs_high", 128'(big_hs), 128'(112));
    check("big_vs_high", 128'(big_vs), 128'(3 * 1688));
    check("big_last_disp", 128'(big_last.disp), 128'(1));
    check("big_last_x", 128'(big_last.x), 128'(1279));
    check("big_last_y", 128'(big_last.y), 128'(3));
    check("big_last_col", 128'(big_last.col), 128'(159));
    check("big_last_cx", 128'(big_last.cx), 128'(7));
    check("big_last_row", 128'(big_last.row), 128'(0));
    check("big_last_cy", 128'(big_last.cy), 128'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_pipe.md
# vga_timing_pipe

Parametrised VGA raster timing generator: the next generation of the text-mode timer. It adds configurable sync polarity, text-cell coordinate generation without dividers, frame and line strobes, and a configurable output pipeline delay. The delay lets sync and display signals line up with the downstream character-RAM and font-ROM fetch latency. It sits between the pixel clock domain root and the text renderer.

## Interface
- H_SYNC, 112, horizontal sync width (clocks)
- H_BACK, 248, horizontal back porch
- H_DISP, 1280, visible pixels per line
- H_FRONT, 48, horizontal front porch
- V_SYNC, 3; V_BACK, 38; V_DISP, 1024; V_FRONT, 1: vertical equivalents (lines)
- HS_POL, 0, level of vga_hs during sync pulse (0 = active-low)
- VS_POL, 0, level of vga_vs during sync pulse
- CELL_W, 8, glyph width in pixels (≥1, any value)
- CELL_H, 16, glyph height in lines (≥1, any value)
- PIPE_DELAY, 2, register stages from counter state to outputs (≥1)
- Derived widths: XW=$clog2(H_DISP), YW=$clog2(V_DISP), CW=$clog2(ceil(H_DISP/CELL_W)), RW=$clog2(ceil(V_DISP/CELL_H)), CXW=$clog2(CELL_W) (min 1), CYW=$clog2(CELL_H) (min 1)
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- vga_hs  out  1  horizontal sync, polarity HS_POL
- vga_vs  out  1  vertical sync, polarity VS_POL
- disp  out  1  visible-pixel qualifier
- x_pos  out  XW  visible column, 0 when disp=0
- y_pos  out  YW  visible line, 0 when disp=0
- col  out  CW  text column = x_pos / CELL_W
- row  out  RW  text row = y_pos / CELL_H
- cell_x  out  CXW  x_pos % CELL_W
- cell_y  out  CYW  y_pos % CELL_H
- line_start  out  1  one-cycle pulse with the first visible pixel of every visible line
- frame_start  out  1  one-cycle pulse with pixel (0,0) of every frame

## Operation
- Counters: x_cnt 0..H_LIMIT-1, where H_LIMIT=sum of the H_* parameters, wraps to 0. y_cnt 0..V_LIMIT-1 advances when x_cnt wraps and itself wraps to 0.
- Stage 0 (combinational from counters):
  - hs active when x_cnt < H_SYNC; vs active when y_cnt < V_SYNC.
  - disp when H_SYNC+H_BACK ≤ x_cnt < H_SYNC+H_BACK+H_DISP and likewise for y.
- Cell counters are registers updated in lockstep with x_cnt/y_cnt. No divide or modulo hardware.
  - cell_x/col clear when x_cnt enters the visible region. Inside the region cell_x increments; when it is at CELL_W-1 it wraps to 0 and col increments.
  - cell_y/row clear on the line transition into the first visible line. On each line transition within the visible region cell_y increments; at CELL_H-1 it wraps to 0 and row increments.
- Partial last cell allowed when H_DISP or V_DISP is not a multiple of the cell size. col/row then reach ceil(...)-1.
- Stage-0 bundle: hs, vs, disp, x_pos, y_pos, col, row, cell_x, cell_y, line_start, frame_start.
  - When disp=0, all position fields are forced to 0.
  - line_start = disp and x_pos==0.
  - frame_start = line_start and y_pos==0.
- The bundle passes through PIPE_DELAY register stages. Outputs are the last stage; there is no combinational path from the counters to the ports.

## Timing
- Reset asserted: counters, cell counters and every pipeline stage clear immediately.
  - vga_hs=~HS_POL, vga_vs=~VS_POL.
  - disp, line_start, frame_start = 0; all position outputs = 0.
- Counter state index n = y_cnt·H_LIMIT + x_cnt. The state during reset is n=0, and each clk edge advances n by 1.
- Outputs after edge k reflect state n = k-PIPE_DELAY. Before that, outputs hold their reset values.
- Reset mid-frame: asynchronous clear of everything. Restart is identical to power-up; no partial frame is replayed.
- Wrap: the state after n=H_LIMIT·V_LIMIT-1 is n=0. Output phase continues seamlessly with no gap cycle.
- frame_start and line_start are exactly one clock wide and coincide with disp rising at that pixel.

## Test plan
- Small config: H 2/3/8/1 (H_LIMIT 14), V 1/1/4/1 (V_LIMIT 7), CELL_W=3, CELL_H=2, PIPE_DELAY=2, polarities 0. Release reset, run two frames (196 clocks):
  - vga_hs low for 2 of every 14 clocks, first low after edge 2.
  - vga_vs low for 14 clocks per 98.
  - disp high 32 clocks per frame.
- Same config: frame_start is high only after edges 35 and 133. line_start is high after edges 35, 49, 63, 77 in the first frame.
- Along a visible line: x_pos 0..7 gives cell_x 0,1,2,0,1,2,0,1 and col 0,0,0,1,1,1,2,2. Across lines, y_pos 0..3 gives cell_y 0,1,0,1 and row 0,0,1,1. All position outputs are 0 whenever disp=0.
- Default 1280x1024 config, PIPE_DELAY=1, HS_POL=1, VS_POL=1:
  - hs high 112 of 1688 clocks; vs high 3 of 1066 lines.
  - On the last visible pixel: x_pos=1279, y_pos=1023, col=159, row=63, cell_x=7, cell_y=15.
- Assert reset for 1 clock at an arbitrary mid-frame point:
  - All outputs immediately take their reset values.
  - After release, the output sequence matches the power-up sequence clock-for-clock.
- PIPE_DELAY sweep 1,3,5 on the small config: the output stream equals the PIPE_DELAY=1 stream shifted by PIPE_DELAY-1 clocks.
